voice_scheduler: RTL and testbench
==================================

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 SHALL have parameter N, default 8; meaning: number of voices sharing the note-to-sample engine, N >= 2, power of two.
REQ-002 SHALL have parameter TIMEOUT, default 255; meaning: maximum cycles to wait for engine done.
REQ-003 SHALL have port clk, input, 1, the single clock; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req, input, N, one-cycle per-voice sample-request pulses.
REQ-006 SHALL have port done, input, 1, engine completion pulse for the current job.
REQ-007 SHALL have port frame_tick, input, 1, one-cycle pulse marking the start of an audio sample frame.
REQ-008 SHALL have port start, output, 1, one-cycle pulse launching an engine job.
REQ-009 SHALL have port voice_idx, output, log2(N), binary index of the granted voice.
REQ-010 SHALL have port grant, output, N, one-hot grant, all zeros when idle.
REQ-011 SHALL have port pending, output, N, latched outstanding requests.
REQ-012 SHALL have port timeout_err, output, 1, sticky watchdog flag.
REQ-013 SHALL have port overrun, output, 1, sticky missed-frame flag.

Function
REQ-014 SHALL register every output.
REQ-015 SHALL set pending[i] on any clock edge where req[i]=1; an existing pending bit absorbs repeat requests with no counting.
REQ-016 SHALL implement states IDLE, ISSUE, WAIT.
REQ-017 IDLE: if pending != 0, SHALL select a voice, load grant/voice_idx and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-018 Selection SHALL be round-robin: the first set pending bit scanning from index ptr upward, wrapping from N-1 to 0.
REQ-019 ISSUE: SHALL assert start for exactly one cycle, clear the watchdog counter and go to WAIT.
REQ-020 WAIT: on done=1, SHALL clear pending[voice_idx], set ptr=(voice_idx+1) mod N, clear grant and return to IDLE.
REQ-021 If req[voice_idx]=1 on the same edge as done, pending[voice_idx] SHALL remain set, and that voice is served again only after all other pending voices (by REQ-018).
REQ-022 WAIT: the watchdog SHALL count once per cycle; on reaching TIMEOUT without done, SHALL set timeout_err and then behave exactly as REQ-020.
REQ-023 done outside WAIT SHALL be ignored.
REQ-024 Latency: req at edge e gives pending at e+1, and grant at e+2 when IDLE and ptr favours that voice; start is high in the cycle after e+2.
REQ-025 Back-to-back jobs SHALL be separated by no fewer than 2 cycles (done edge, then IDLE edge).
REQ-026 On frame_tick=1 with pending != 0 on the same edge, overrun SHALL set.
REQ-027 voice_idx SHALL equal the index of the single set grant bit whenever grant != 0.
REQ-028 ptr SHALL wrap from N-1 to 0 with no out-of-range value.

Reset
REQ-029 reset_n=0 SHALL immediately force state IDLE, ptr=0, pending=0, grant=0, voice_idx=0, start=0, timeout_err=0, overrun=0, watchdog=0, regardless of clk.
REQ-030 Reset asserted mid-job SHALL abandon the job silently; a later done SHALL be ignored.
REQ-031 timeout_err and overrun SHALL clear only on reset.

Verification
REQ-032 Single request: req=8'b0000_1000 pulse -> grant=8'b0000_1000, voice_idx=3, one start pulse; done -> pending=0, grant=0, ptr=4.
REQ-033 Round-robin fairness: pending=8'b1000_1001 with ptr=0, done returned each job -> grant order 0, 3, 7; then new req 8'b0000_0001 -> voice 0.
REQ-034 Wrap and fairness: ptr=4, pending=8'b0000_0101 -> voice 0, then voice 2; re-request of voice 0 coincident with its done -> voice 2 served before voice 0.
REQ-035 Watchdog: grant voice 5, withhold done for TIMEOUT cycles -> timeout_err=1, pending[5]=0, ptr=6, return to IDLE; stray done later ignored.
REQ-036 Overrun/reset: frame_tick while pending=8'b0100_0000 -> overrun=1; reset_n low mid-WAIT -> all outputs zero asynchronously, overrun=0.

Source files
------------

// File: rtl/voice_scheduler.sv
// Round-robin scheduler granting one of N voices at a time to a shared
// note-to-sample engine, with a job watchdog and a missed-frame flag.
module voice_scheduler #(
  parameter int N       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  input  logic                 done,
  input  logic                 frame_tick,
  output logic                 start,
  output logic [$clog2(N)-1:0] voice_idx,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         pending,
  output logic                 timeout_err,
  output logic                 overrun,
  output logic [1:0]           state_dbg
);
  localparam int LW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT + 1);

  // Handshake: start is a one-cycle launch pulse; the engine answers with a
  // one-cycle done pulse, which is only honoured while a job is in WAIT.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [LW-1:0]   vidx_q, vidx_d;
  logic            start_q, start_d;
  logic            terr_q, terr_d;
  logic            ovr_q, ovr_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic [N-1:0]    clr;
  logic            sel_found;
  logic [LW-1:0]   sel_idx;
  logic [LW-1:0]   cand;

  // First pending voice at or above ptr, wrapping naturally in LW bits.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr_q + LW'(k);
      if (!sel_found && pending_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    vidx_d  = vidx_q;
    start_d = 1'b0;
    wdog_d  = wdog_q;
    clr     = '0;
    terr_d  = terr_q;
    ovr_d   = ovr_q | (frame_tick & (|pending_q));
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = {{(N-1){1'b0}}, 1'b1} << sel_idx;
          vidx_d  = sel_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        start_d = 1'b1;
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + WW'(1);
        // A done arriving on the expiry cycle still counts as a clean finish.
        if (done || (wdog_q == WW'(TIMEOUT - 1))) begin
          if (!done) terr_d = 1'b1;
          clr[vidx_q] = 1'b1;
          ptr_d       = vidx_q + LW'(1);
          grant_d     = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q & ~clr) | req;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      pending_q <= '0;
      grant_q   <= '0;
      vidx_q    <= '0;
      start_q   <= 1'b0;
      terr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      vidx_q    <= vidx_d;
      start_q   <= start_d;
      terr_q    <= terr_d;
      ovr_q     <= ovr_d;
      wdog_q    <= wdog_d;
    end
  end

  assign start       = start_q;
  assign voice_idx   = vidx_q;
  assign grant       = grant_q;
  assign pending     = pending_q;
  assign timeout_err = terr_q;
  assign overrun     = ovr_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a job-level reference model.
module tb_voice_scheduler;
  localparam int N       = 8;
  localparam int LW      = $clog2(N);
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [N-1:0]  req = '0;
  logic          done = 1'b0;
  logic          frame_tick = 1'b0;
  logic          start;
  logic [LW-1:0] voice_idx;
  logic [N-1:0]  grant;
  logic [N-1:0]  pending;
  logic          timeout_err;
  logic          overrun;
  logic [1:0]    state_dbg;

  int n_pass  = 0;
  int n_total = 0;
  bit checking = 1'b0;

  voice_scheduler #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done), .frame_tick(frame_tick),
    .start(start), .voice_idx(voice_idx), .grant(grant), .pending(pending),
    .timeout_err(timeout_err), .overrun(overrun), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A job is tracked by the voice it serves (m_cur, -1 when none) and its age
  // in clock edges since it was granted: age 1 launches, later edges wait.
  bit [N-1:0]    m_pend;
  int            m_ptr, m_cur, m_idx, m_age;
  bit            m_terr, m_ovr;
  bit [N-1:0]    m_nxt, m_mask;
  logic [LW-1:0] exp_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = '0; m_ptr = 0; m_cur = -1; m_idx = 0; m_age = 0;
      m_terr = 1'b0; m_ovr = 1'b0;
      exp_q.delete();
    end else begin
      if (frame_tick && m_pend != 0) m_ovr = 1'b1;
      m_nxt = m_pend | req;
      if (m_cur < 0) begin
        if (m_pend != 0) begin
          for (int k = 0; k < N; k++)
            if (m_cur < 0 && m_pend[(m_ptr + k) % N]) m_cur = (m_ptr + k) % N;
          m_idx = m_cur;
          m_age = 0;
          exp_q.push_back(LW'(m_cur));
        end
      end else begin
        m_age++;
        if (m_age >= 2 && (done || (m_age - 1 == TIMEOUT))) begin
          if (!done) m_terr = 1'b1;
          m_mask = '0;
          m_mask[m_cur] = 1'b1;
          m_nxt = (m_pend & ~m_mask) | req;
          m_ptr = (m_cur + 1) % N;
          m_cur = -1;
        end
      end
      m_pend = m_nxt;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (checking && reset_n) begin
      bit [N-1:0] eg;
      eg = '0;
      if (m_cur >= 0) eg[m_cur] = 1'b1;
      chk("grant", grant, eg);
      chk("voice_idx", voice_idx, m_idx);
      chk("start", start, (m_cur >= 0 && m_age == 1));
      chk("pending", pending, m_pend);
      chk("timeout_err", timeout_err, m_terr);
      chk("overrun", overrun, m_ovr);
      if (start === 1'b1) begin
        if (exp_q.size() == 0) chk("start_unexpected", 1, 0);
        else chk("start_voice", voice_idx, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc(input logic [N-1:0] r, input logic d, input logic f);
    req = r; done = d; frame_tick = f;
    @(negedge clk);
    req = '0; done = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic serve();
    cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b1, 1'b0);
  endtask

  // Asserted between clock edges so the clear must be asynchronous.
  task automatic do_reset(input bit check_now);
    #2 reset_n = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_grant", grant, 0);
      chk("rst_pending", pending, 0);
      chk("rst_start", start, 0);
      chk("rst_voice_idx", voice_idx, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_overrun", overrun, 0);
    end
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    do_reset(1'b1);
    checking = 1'b1;

    // single request on voice 3
    cyc(8'h08, 1'b0, 1'b0);
    chk("s1_pending", pending, 8'h08);
    cyc('0, 1'b0, 1'b0);
    chk("s1_grant", grant, 8'h08);
    chk("s1_idx", voice_idx, 3);
    chk("s1_nostart", start, 0);
    cyc('0, 1'b0, 1'b0);
    chk("s1_start", start, 1);
    cyc('0, 1'b0, 1'b0);
    chk("s1_start_once", start, 0);
    cyc('0, 1'b1, 1'b0);
    chk("s1_done_grant", grant, 0);
    chk("s1_done_pending", pending, 0);

    // wrap from ptr 4 and re-request coincident with done
    cyc(8'h05, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    chk("s2_first_v0", grant, 8'h01);
    cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    cyc(8'h01, 1'b1, 1'b0);
    chk("s2_rereq_pending", pending, 8'h05);
    cyc('0, 1'b0, 1'b0);
    chk("s2_then_v2", grant, 8'h04);
    serve();
    cyc('0, 1'b0, 1'b0);
    chk("s2_then_v0", grant, 8'h01);
    serve();

    // round-robin 0, 3, 7 then 0
    do_reset(1'b0);
    cyc(8'h89, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    chk("s3_v0", grant, 8'h01);
    serve();
    cyc('0, 1'b0, 1'b0);
    chk("s3_v3", grant, 8'h08);
    serve();
    cyc('0, 1'b0, 1'b0);
    chk("s3_v7", grant, 8'h80);
    serve();
    cyc(8'h01, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    chk("s3_again_v0", grant, 8'h01);
    serve();

    // watchdog on voice 5
    do_reset(1'b0);
    cyc(8'h20, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    chk("s4_grant5", voice_idx, 5);
    cyc('0, 1'b0, 1'b0);
    repeat (TIMEOUT - 1) cyc('0, 1'b0, 1'b0);
    chk("s4_not_yet", timeout_err, 0);
    chk("s4_still_granted", grant, 8'h20);
    cyc('0, 1'b0, 1'b0);
    chk("s4_timeout", timeout_err, 1);
    chk("s4_pending", pending, 0);
    chk("s4_grant_clr", grant, 0);
    cyc('0, 1'b1, 1'b0);
    chk("s4_stray_done", pending, 0);
    cyc(8'h41, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    chk("s4_ptr6", grant, 8'h40);
    serve();
    chk("s4_sticky", timeout_err, 1);

    // overrun, then reset mid-WAIT
    do_reset(1'b0);
    cyc('0, 1'b0, 1'b1);
    chk("s5_no_overrun", overrun, 0);
    cyc(8'h40, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b1);
    chk("s5_overrun", overrun, 1);
    cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    do_reset(1'b1);
    cyc('0, 1'b1, 1'b0);
    chk("s5_late_done_grant", grant, 0);
    chk("s5_late_done_start", start, 0);
    chk("s5_late_done_pending", pending, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 499) == 0) do_reset(1'b0);
      else cyc(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0));
    end
    cyc('0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
